// File: rtl/pc_ctrl_pkg.sv
// Shared definitions for the program-counter controller: next-PC select codes.
package pc_ctrl_pkg;

  localparam int SEL_W = 3;

  typedef enum logic [SEL_W-1:0] {
    SEL_HOLD = 3'd0,
    SEL_RET  = 3'd1,
    SEL_CALL = 3'd2,
    SEL_JUMP = 3'd3,
    SEL_BR   = 3'd4,
    SEL_INC  = 3'd5
  } sel_t;

endpackage

// File: rtl/pc_ctrl_ret_stack.sv
// Return-address LIFO: register array indexed by the depth pointer; top_dat is the newest entry.
// Updates on the clock edge after push/pop; a push when full or a pop when empty is dropped and flagged.
module pc_ctrl_ret_stack #(
  parameter int W     = 4,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               push_dat,
  output logic [W-1:0]               top_dat,
  output logic [$clog2(DEPTH+1)-1:0] depth,
  output logic                       full,
  output logic                       empty,
  output logic                       ovf,
  output logic                       udf
);

  localparam int DW = $clog2(DEPTH + 1);

  logic [W-1:0] mem [DEPTH];
  logic         do_push;
  logic         do_pop;

  assign full    = (depth == DW'(DEPTH));
  assign empty   = (depth == '0);
  assign ovf     = push & full;
  assign udf     = pop & empty;
  // Pop takes precedence if both are requested in the same cycle.
  assign do_pop  = pop & ~empty;
  assign do_push = push & ~full & ~pop;

  always_comb begin
    top_dat = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (DW'(i + 1) == depth) top_dat = mem[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      depth <= '0;
    end else if (do_pop) begin
      depth <= depth - DW'(1);
    end else if (do_push) begin
      depth <= depth + DW'(1);
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (do_push && (DW'(i) == depth)) mem[i] <= push_dat;
    end
  end

endmodule

// File: rtl/pc_ctrl.sv
// Program-counter controller with stall, jump, relative branch and call/return via a return-address stack.
// One-cycle latency from control inputs to PC_CURR; stall freezes PC, stack and error flag.
module pc_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter int           W         = 4,
  parameter int           DEPTH     = 2,
  parameter logic [W-1:0] RESET_VEC = '0
) (
  input  logic                       clk,
  input  logic                       set_pc,
  input  logic                       stall,
  input  logic                       jump,
  input  logic [W-1:0]               jump_addr,
  input  logic                       branch,
  input  logic [W-1:0]               branch_off,
  input  logic                       call,
  input  logic [W-1:0]               call_addr,
  input  logic                       ret,
  output logic [W-1:0]               PC_CURR,
  output logic [$clog2(DEPTH+1)-1:0] stack_depth,
  output logic                       stack_full,
  output logic                       stack_empty,
  output logic                       stack_err
);

  sel_t         sel;
  logic [W-1:0] next_pc;
  logic [W-1:0] top_dat;
  logic [W-1:0] pc_inc;
  logic         push;
  logic         pop;
  logic         ovf;
  logic         udf;

  assign pc_inc = PC_CURR + W'(1);

  // Only the winning request reaches the stack, so losing call/ret never push or pop.
  assign pop  = ~set_pc & ~stall & ret;
  assign push = ~set_pc & ~stall & ~ret & call;

  always_comb begin
    sel = SEL_INC;
    if (stall) begin
      sel = SEL_HOLD;
    end else if (ret) begin
      sel = stack_empty ? SEL_HOLD : SEL_RET;
    end else if (call) begin
      sel = stack_full ? SEL_HOLD : SEL_CALL;
    end else if (jump) begin
      sel = SEL_JUMP;
    end else if (branch) begin
      sel = SEL_BR;
    end
  end

  always_comb begin
    next_pc = pc_inc;
    unique case (sel)
      SEL_HOLD: next_pc = PC_CURR;
      SEL_RET:  next_pc = top_dat;
      SEL_CALL: next_pc = call_addr;
      SEL_JUMP: next_pc = jump_addr;
      SEL_BR:   next_pc = PC_CURR + branch_off;
      SEL_INC:  next_pc = pc_inc;
      default:  next_pc = pc_inc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (set_pc) begin
      PC_CURR   <= RESET_VEC;
      stack_err <= 1'b0;
    end else begin
      PC_CURR <= next_pc;
      if (ovf || udf) stack_err <= 1'b1;
    end
  end

  pc_ctrl_ret_stack #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_ret_stack (
    .clk      (clk),
    .rst      (set_pc),
    .push     (push),
    .pop      (pop),
    .push_dat (pc_inc),
    .top_dat  (top_dat),
    .depth    (stack_depth),
    .full     (stack_full),
    .empty    (stack_empty),
    .ovf      (ovf),
    .udf      (udf)
  );

endmodule

// File: tb/tb_pc_ctrl.sv
// Directed bench for pc_ctrl at W=4, DEPTH=2, RESET_VEC=0.
module tb_pc_ctrl;

  logic       clk = 1'b0;
  logic       set_pc = 1'b0;
  logic       stall = 1'b0;
  logic       jump = 1'b0;
  logic [3:0] jump_addr = '0;
  logic       branch = 1'b0;
  logic [3:0] branch_off = '0;
  logic       call = 1'b0;
  logic [3:0] call_addr = '0;
  logic       ret = 1'b0;
  logic [3:0] PC_CURR;
  logic [1:0] stack_depth;
  logic       stack_full;
  logic       stack_empty;
  logic       stack_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pc_ctrl #(
    .W         (4),
    .DEPTH     (2),
    .RESET_VEC (4'h0)
  ) dut (
    .clk         (clk),
    .set_pc      (set_pc),
    .stall       (stall),
    .jump        (jump),
    .jump_addr   (jump_addr),
    .branch      (branch),
    .branch_off  (branch_off),
    .call        (call),
    .call_addr   (call_addr),
    .ret         (ret),
    .PC_CURR     (PC_CURR),
    .stack_depth (stack_depth),
    .stack_full  (stack_full),
    .stack_empty (stack_empty),
    .stack_err   (stack_err)
  );

  task automatic idle();
    set_pc = 0; stall = 0; jump = 0; branch = 0; call = 0; ret = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic do_jump(input logic [3:0] a);
    jump = 1; jump_addr = a; step();
  endtask

  task automatic do_call(input logic [3:0] a);
    call = 1; call_addr = a; step();
  endtask

  task automatic test_reset();
    set_pc = 1; step();
    checks++; if (PC_CURR !== 4'h0) begin errors++; $display("FAIL reset_pc got %h want 0", PC_CURR); end
    checks++; if (stack_empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b want 1", stack_empty); end
    checks++; if (stack_depth !== 2'd0) begin errors++; $display("FAIL reset_depth got %0d want 0", stack_depth); end
    checks++; if (stack_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", stack_err); end
    checks++; if (stack_full !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", stack_full); end
    for (int i = 1; i <= 16; i++) begin
      logic [3:0] exp_pc;
      exp_pc = 4'(i);
      step();
      checks++; if (PC_CURR !== exp_pc) begin errors++; $display("FAIL wrap_%0d got %h want %h", i, PC_CURR, exp_pc); end
    end
  endtask

  task automatic test_jump_branch_stall();
    do_jump(4'h3);
    checks++; if (PC_CURR !== 4'h3) begin errors++; $display("FAIL jump3 got %h want 3", PC_CURR); end
    do_jump(4'h9);
    checks++; if (PC_CURR !== 4'h9) begin errors++; $display("FAIL jump9 got %h want 9", PC_CURR); end
    branch = 1; branch_off = 4'b1110; step();
    checks++; if (PC_CURR !== 4'h7) begin errors++; $display("FAIL branch_neg got %h want 7", PC_CURR); end
    stall = 1; jump = 1; jump_addr = 4'h2; step();
    checks++; if (PC_CURR !== 4'h7) begin errors++; $display("FAIL stall_hold got %h want 7", PC_CURR); end
    branch = 1; branch_off = 4'h5; step();
    checks++; if (PC_CURR !== 4'hC) begin errors++; $display("FAIL branch_pos got %h want c", PC_CURR); end
  endtask

  task automatic test_call_ret();
    do_jump(4'h2);
    do_call(4'hA);
    checks++; if (PC_CURR !== 4'hA || stack_depth !== 2'd1) begin errors++; $display("FAIL call1 got pc=%h d=%0d want pc=a d=1", PC_CURR, stack_depth); end
    do_call(4'hC);
    checks++; if (PC_CURR !== 4'hC || stack_depth !== 2'd2 || stack_full !== 1'b1) begin errors++; $display("FAIL call2 got pc=%h d=%0d f=%b want pc=c d=2 f=1", PC_CURR, stack_depth, stack_full); end
    checks++; if (stack_err !== 1'b0) begin errors++; $display("FAIL err_before_ovf got %b want 0", stack_err); end
    do_call(4'h5);
    checks++; if (PC_CURR !== 4'hC || stack_err !== 1'b1 || stack_depth !== 2'd2) begin errors++; $display("FAIL overflow got pc=%h e=%b d=%0d want pc=c e=1 d=2", PC_CURR, stack_err, stack_depth); end
    ret = 1; step();
    checks++; if (PC_CURR !== 4'hB || stack_depth !== 2'd1) begin errors++; $display("FAIL ret1 got pc=%h d=%0d want pc=b d=1", PC_CURR, stack_depth); end
    ret = 1; step();
    checks++; if (PC_CURR !== 4'h3 || stack_empty !== 1'b1) begin errors++; $display("FAIL ret2 got pc=%h empty=%b want pc=3 empty=1", PC_CURR, stack_empty); end
    ret = 1; step();
    checks++; if (PC_CURR !== 4'h3 || stack_err !== 1'b1) begin errors++; $display("FAIL underflow got pc=%h e=%b want pc=3 e=1", PC_CURR, stack_err); end
    step();
    checks++; if (PC_CURR !== 4'h4 || stack_err !== 1'b1) begin errors++; $display("FAIL err_sticky got pc=%h e=%b want pc=4 e=1", PC_CURR, stack_err); end
  endtask

  task automatic test_priority();
    set_pc = 1; step();
    do_jump(4'h3);
    do_call(4'h6);
    checks++; if (PC_CURR !== 4'h6 || stack_depth !== 2'd1) begin errors++; $display("FAIL prio_setup got pc=%h d=%0d want pc=6 d=1", PC_CURR, stack_depth); end
    call = 1; call_addr = 4'hE; ret = 1; step();
    checks++; if (PC_CURR !== 4'h4 || stack_depth !== 2'd0) begin errors++; $display("FAIL call_ret got pc=%h d=%0d want pc=4 d=0", PC_CURR, stack_depth); end
    do_jump(4'h6);
    call = 1; call_addr = 4'h8; jump = 1; jump_addr = 4'h1; step();
    checks++; if (PC_CURR !== 4'h8 || stack_depth !== 2'd1) begin errors++; $display("FAIL call_jump got pc=%h d=%0d want pc=8 d=1", PC_CURR, stack_depth); end
    stall = 1; ret = 1; step();
    checks++; if (PC_CURR !== 4'h8 || stack_depth !== 2'd1) begin errors++; $display("FAIL stall_ret got pc=%h d=%0d want pc=8 d=1", PC_CURR, stack_depth); end
    ret = 1; step();
    checks++; if (PC_CURR !== 4'h7 || stack_depth !== 2'd0) begin errors++; $display("FAIL top_is_7 got pc=%h d=%0d want pc=7 d=0", PC_CURR, stack_depth); end
    checks++; if (stack_err !== 1'b0) begin errors++; $display("FAIL prio_no_err got %b want 0", stack_err); end
  endtask

  task automatic test_reset_mid();
    do_call(4'h1);
    do_call(4'h2);
    do_call(4'h3);
    checks++; if (stack_depth !== 2'd2 || stack_err !== 1'b1) begin errors++; $display("FAIL mid_setup got d=%0d e=%b want d=2 e=1", stack_depth, stack_err); end
    set_pc = 1; stall = 1; call = 1; call_addr = 4'h9; step();
    checks++; if (PC_CURR !== 4'h0 || stack_depth !== 2'd0 || stack_err !== 1'b0 || stack_empty !== 1'b1) begin
      errors++; $display("FAIL reset_mid got pc=%h d=%0d e=%b empty=%b want pc=0 d=0 e=0 empty=1", PC_CURR, stack_depth, stack_err, stack_empty);
    end
    step();
    checks++; if (PC_CURR !== 4'h1) begin errors++; $display("FAIL after_reset_mid got %h want 1", PC_CURR); end
  endtask

  task automatic test_ret_wrap();
    do_jump(4'hF);
    do_call(4'h3);
    checks++; if (PC_CURR !== 4'h3 || stack_depth !== 2'd1) begin errors++; $display("FAIL wrap_call got pc=%h d=%0d want pc=3 d=1", PC_CURR, stack_depth); end
    ret = 1; step();
    checks++; if (PC_CURR !== 4'h0 || stack_empty !== 1'b1) begin errors++; $display("FAIL wrap_ret got pc=%h empty=%b want pc=0 empty=1", PC_CURR, stack_empty); end
  endtask

  initial begin
    idle();
    test_reset();
    test_jump_branch_stall();
    test_call_ret();
    test_priority();
    test_reset_mid();
    test_ret_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
